// File: rtl/axi_lite_regmap_slave_if.sv
// PS-side bus of the register-map slave: write address, write data,
// write response, read address, read data and read response channels.
interface axi_lite_regmap_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] waddr_data;
  logic                  waddr_valid;
  logic                  waddr_ready;
  logic [DATA_WIDTH-1:0] wdata_data;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [1:0]            wresp_data;
  logic                  wresp_valid;
  logic                  wresp_ready;
  logic [ADDR_WIDTH-1:0] raddr_data;
  logic                  raddr_valid;
  logic                  raddr_ready;
  logic [DATA_WIDTH-1:0] rdata_data;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [1:0]            rresp_data;
  logic                  rresp_valid;
  logic                  rresp_ready;

  modport master (
    output waddr_data, waddr_valid,
    input  waddr_ready,
    output wdata_data, wdata_valid,
    input  wdata_ready,
    input  wresp_data, wresp_valid,
    output wresp_ready,
    output raddr_data, raddr_valid,
    input  raddr_ready,
    input  rdata_data, rdata_valid,
    output rdata_ready,
    input  rresp_data, rresp_valid,
    output rresp_ready
  );

  modport slave (
    input  waddr_data, waddr_valid,
    output waddr_ready,
    input  wdata_data, wdata_valid,
    output wdata_ready,
    output wresp_data, wresp_valid,
    input  wresp_ready,
    input  raddr_data, raddr_valid,
    output raddr_ready,
    output rdata_data, rdata_valid,
    input  rdata_ready,
    output rresp_data, rresp_valid,
    input  rresp_ready
  );
endinterface

// File: rtl/axi_lite_regmap_slave.sv
// Register-file slave shared by the PS bus and RTL fabric.
// Ports: clk, rst (async low), bus (PS channels), per-register RTL
// write/read/poll strobes, clr_rd_out, rtl_rd_out, fresh_bits.
module axi_lite_regmap_slave #(
  parameter int MEM_SIZE   = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  axi_lite_regmap_slave_if.slave bus,
  input  logic [MEM_SIZE-1:0] rtl_write_reqs,
  input  logic [MEM_SIZE-1:0][DATA_WIDTH-1:0] rtl_wd_in,
  input  logic [MEM_SIZE-1:0] rtl_read_reqs,
  input  logic clr_rd_out,
  input  logic [MEM_SIZE-1:0] rtl_rdy,
  output logic [MEM_SIZE-1:0][DATA_WIDTH-1:0] rtl_rd_out,
  output logic [MEM_SIZE-1:0] fresh_bits
);

  localparam int IW   = $clog2(MEM_SIZE);
  localparam int CEIL = MEM_SIZE - 1;
  localparam logic [IW-1:0] CEIL_IDX = IW'(CEIL);
  localparam logic [DATA_WIDTH-1:0] CEIL_VAL =
    {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic {
    WS_FILL,
    WS_RESP
  } wr_state_e;

  // Word index; everything at or past the top folds onto the ceiling.
  function automatic logic [IW-1:0] decode(
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [ADDR_WIDTH-1:0] word;
    word = addr >> 2;
    if (word >= ADDR_WIDTH'(CEIL)) return CEIL_IDX;
    return word[IW-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [MEM_SIZE];
  logic [MEM_SIZE-1:0][DATA_WIDTH-1:0] rd_out_q, rd_out_d;
  logic [MEM_SIZE-1:0] fresh_q, fresh_d;

  wr_state_e ws_q, ws_d;
  logic aw_full_q, aw_full_d;
  logic [IW-1:0] aw_idx_q, aw_idx_d;
  logic w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;

  logic rv_q, rv_d;
  logic rr_q, rr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic ps_write_req;
  logic wcomplete;
  logic raddr_ready_c;

  assign ps_write_req = (ws_q == WS_FILL) & aw_full_q & w_full_q;
  // An RTL write to the same word this cycle defers the commit.
  assign wcomplete = ps_write_req & ~rtl_write_reqs[aw_idx_q];

  assign raddr_ready_c = ~(rv_q | rr_q);

  assign bus.waddr_ready = ~aw_full_q;
  assign bus.wdata_ready = ~w_full_q;
  assign bus.wresp_valid = (ws_q == WS_RESP);
  assign bus.wresp_data  = 2'b00;
  assign bus.raddr_ready = raddr_ready_c;
  assign bus.rdata_valid = rv_q;
  assign bus.rdata_data  = rdata_q;
  assign bus.rresp_valid = rr_q;
  assign bus.rresp_data  = 2'b00;

  assign rtl_rd_out = rd_out_q;
  assign fresh_bits = fresh_q;

  always_comb begin
    ws_d      = ws_q;
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    if (bus.waddr_valid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_idx_d  = decode(bus.waddr_data);
    end
    if (bus.wdata_valid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = bus.wdata_data;
    end
    unique case (ws_q)
      WS_FILL: begin
        if (wcomplete) ws_d = WS_RESP;
      end
      WS_RESP: begin
        if (bus.wresp_ready) begin
          ws_d      = WS_FILL;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      default: ws_d = WS_FILL;
    endcase
  end

  always_comb begin
    rv_d    = rv_q & ~bus.rdata_ready;
    rr_d    = rr_q & ~bus.rresp_ready;
    rdata_d = rdata_q;
    if (bus.raddr_valid && raddr_ready_c) begin
      rv_d    = 1'b1;
      rr_d    = 1'b1;
      rdata_d = mem_q[decode(bus.raddr_data)];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    rd_out_d = rd_out_q;
    fresh_d  = fresh_q;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (rtl_write_reqs[i]) mem_d[i] = rtl_wd_in[i];
    end
    if (wcomplete && aw_idx_q != CEIL_IDX) begin
      mem_d[aw_idx_q] = w_data_q;
    end
    mem_d[CEIL] = CEIL_VAL;
    for (int i = 0; i < MEM_SIZE; i++) begin
      // Loads see the pre-edge word and win over the clear.
      if (rtl_read_reqs[i] || (fresh_q[i] && rtl_rdy[i])) begin
        rd_out_d[i] = mem_q[i];
      end else if (clr_rd_out) begin
        rd_out_d[i] = '0;
      end
      if (fresh_q[i] && rtl_rdy[i]) fresh_d[i] = 1'b0;
    end
    if (wcomplete && aw_idx_q != CEIL_IDX) begin
      fresh_d[aw_idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_q[i] <= (i == CEIL) ? CEIL_VAL : '0;
      end
      rd_out_q  <= '0;
      fresh_q   <= '0;
      ws_q      <= WS_FILL;
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      rv_q      <= 1'b0;
      rr_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_out_q  <= rd_out_d;
      fresh_q   <= fresh_d;
      ws_q      <= ws_d;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      rv_q      <= rv_d;
      rr_q      <= rr_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regmap_slave.sv
// Bench for axi_lite_regmap_slave: vector table, directed corner
// sequences and a randomized run against an array model.
module tb_axi_lite_regmap_slave;

  localparam int N = 64;
  localparam int CEIL = N - 1;
  localparam logic [31:0] NEG2 = 32'hFFFF_FFFE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] rtl_write_reqs = '0;
  logic [N-1:0][31:0] rtl_wd_in = '0;
  logic [N-1:0] rtl_read_reqs = '0;
  logic clr_rd_out = 1'b0;
  logic [N-1:0] rtl_rdy = '1;
  logic [N-1:0][31:0] rtl_rd_out;
  logic [N-1:0] fresh_bits;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [N];

  axi_lite_regmap_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  axi_lite_regmap_slave #(
    .MEM_SIZE(N), .DATA_WIDTH(32), .ADDR_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rtl_write_reqs(rtl_write_reqs), .rtl_wd_in(rtl_wd_in),
    .rtl_read_reqs(rtl_read_reqs), .clr_rd_out(clr_rd_out),
    .rtl_rdy(rtl_rdy), .rtl_rd_out(rtl_rd_out),
    .fresh_bits(fresh_bits)
  );

  always #5 clk = ~clk;

  typedef enum {OP_PSW, OP_PSR, OP_RTLW, OP_RTLR} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] data;
    int          aw_dly;
    int          w_dly;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w >= 32'(CEIL)) ? CEIL : int'(w);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = (i == CEIL) ? NEG2 : 32'h0;
  endtask

  task automatic ps_write(input logic [31:0] addr, input logic [31:0] data,
                          input int aw_dly, input int w_dly, input bit rnd,
                          output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, b_done;
    int cyc;
    aw_done = 0; w_done = 0; b_done = 0; cyc = 0; resp = 2'b11;
    while (!b_done && cyc < 300) begin
      bus.waddr_data  = addr;
      bus.wdata_data  = data;
      bus.waddr_valid = !aw_done && cyc >= aw_dly;
      bus.wdata_valid = !w_done && cyc >= w_dly;
      bus.wresp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.waddr_valid && bus.waddr_ready) aw_done = 1;
      if (bus.wdata_valid && bus.wdata_ready) w_done = 1;
      if (bus.wresp_valid && bus.wresp_ready) begin
        b_done = 1;
        resp = bus.wresp_data;
      end
      tick();
      cyc++;
    end
    bus.waddr_valid = 0;
    bus.wdata_valid = 0;
    bus.wresp_ready = 0;
    ok = b_done;
  endtask

  task automatic ps_read(input logic [31:0] addr, input bit rnd,
                         output logic [31:0] data, output logic [1:0] resp,
                         output bit ok);
    bit a_done, d_done, r_done, seen;
    logic [31:0] first;
    int cyc;
    a_done = 0; d_done = 0; r_done = 0; seen = 0; cyc = 0;
    first = '0; data = '0; resp = 2'b11;
    while (!(a_done && d_done && r_done) && cyc < 300) begin
      bus.raddr_data  = addr;
      bus.raddr_valid = !a_done;
      bus.rdata_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.rresp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.raddr_valid && bus.raddr_ready) a_done = 1;
      if (bus.rdata_valid && !d_done && !seen) begin
        seen = 1;
        first = bus.rdata_data;
      end
      if (bus.rdata_valid && bus.rdata_ready && !d_done) begin
        d_done = 1;
        data = bus.rdata_data;
        check("rdata_hold", bus.rdata_data, first);
      end
      if (bus.rresp_valid && bus.rresp_ready && !r_done) begin
        r_done = 1;
        resp = bus.rresp_data;
      end
      tick();
      cyc++;
    end
    bus.raddr_valid = 0;
    bus.rdata_ready = 0;
    bus.rresp_ready = 0;
    ok = a_done && d_done && r_done;
  endtask

  task automatic rtl_write(input int i, input logic [31:0] v);
    rtl_write_reqs[i] = 1'b1;
    rtl_wd_in[i] = v;
    tick();
    rtl_write_reqs[i] = 1'b0;
  endtask

  task automatic rtl_read(input int i, output logic [31:0] v);
    rtl_read_reqs[i] = 1'b1;
    tick();
    rtl_read_reqs[i] = 1'b0;
    v = rtl_rd_out[i];
  endtask

  task automatic do_psw(input string nm, input logic [31:0] a,
                        input logic [31:0] d, input int ad, input int wd,
                        input bit rnd);
    logic [1:0] resp;
    bit ok;
    ps_write(a, d, ad, wd, rnd, resp, ok);
    check({nm, "_done"}, 32'(ok), 32'd1);
    check({nm, "_wresp"}, 32'(resp), 32'd0);
    if (idx_of(a) != CEIL) model[idx_of(a)] = d;
  endtask

  task automatic do_psr(input string nm, input logic [31:0] a,
                        input logic [31:0] exp, input bit rnd);
    logic [31:0] d;
    logic [1:0] resp;
    bit ok;
    ps_read(a, rnd, d, resp, ok);
    check({nm, "_done"}, 32'(ok), 32'd1);
    check({nm, "_rdata"}, d, exp);
    check({nm, "_rresp"}, 32'(resp), 32'd0);
  endtask

  vec_t tbl [12];
  logic [31:0] v;
  localparam logic [31:0] W = 32'h0000_5A5A;

  initial begin
    tbl[0]  = '{OP_PSW,  32'd0,      32'h1111_1111, 0, 5, 32'h0};
    tbl[1]  = '{OP_RTLR, 32'd0,      32'h0,         0, 0, 32'h1111_1111};
    tbl[2]  = '{OP_PSW,  32'd2,      32'h0000_0022, 9, 0, 32'h0};
    tbl[3]  = '{OP_RTLR, 32'd0,      32'h0,         0, 0, 32'h0000_0022};
    tbl[4]  = '{OP_PSR,  32'd252,    32'h0,         0, 0, NEG2};
    tbl[5]  = '{OP_PSW,  32'd252,    32'd500,       2, 0, 32'h0};
    tbl[6]  = '{OP_PSR,  32'd252,    32'h0,         0, 0, NEG2};
    tbl[7]  = '{OP_PSR,  32'd452,    32'h0,         0, 0, NEG2};
    tbl[8]  = '{OP_PSW,  32'd23,     32'h0000_A5A5, 1, 3, 32'h0};
    tbl[9]  = '{OP_PSR,  32'd20,     32'h0,         0, 0, 32'h0000_A5A5};
    tbl[10] = '{OP_RTLW, 32'd7,      32'h0000_0077, 0, 0, 32'h0};
    tbl[11] = '{OP_RTLR, 32'd7,      32'h0,         0, 0, 32'h0000_0077};

    bus.waddr_valid = 0; bus.waddr_data = '0;
    bus.wdata_valid = 0; bus.wdata_data = '0;
    bus.wresp_ready = 0;
    bus.raddr_valid = 0; bus.raddr_data = '0;
    bus.rdata_ready = 0; bus.rresp_ready = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_waddr_ready", 32'(bus.waddr_ready), 32'd1);
    check("rst_wdata_ready", 32'(bus.wdata_ready), 32'd1);
    check("rst_raddr_ready", 32'(bus.raddr_ready), 32'd1);
    check("rst_valids", {29'd0, bus.wresp_valid, bus.rdata_valid,
                         bus.rresp_valid}, 32'd0);
    check("rst_fresh", fresh_bits[31:0] | fresh_bits[63:32], 32'd0);
    check("rst_rd_out0", rtl_rd_out[0], 32'd0);
    rst = 1'b1;
    tick();
    do_psr("rst_mem3", 32'd12, 32'd0, 0);
    rtl_read(CEIL, v);
    check("rst_ceil_rtl", v, NEG2);

    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 12; k++) begin
        unique case (tbl[k].op)
          OP_PSW: do_psw($sformatf("tbl%0d", k), tbl[k].addr, tbl[k].data,
                         tbl[k].aw_dly, tbl[k].w_dly, pass[0]);
          OP_PSR: do_psr($sformatf("tbl%0d", k), tbl[k].addr, tbl[k].exp,
                         pass[0]);
          OP_RTLW: begin
            rtl_write(int'(tbl[k].addr), tbl[k].data);
            model[tbl[k].addr] = tbl[k].data;
          end
          OP_RTLR: begin
            rtl_read(int'(tbl[k].addr), v);
            check($sformatf("tbl%0d_rtl_rd", k), v, tbl[k].exp);
          end
        endcase
      end
    end

    // Held RTL writes on 8..11 block a PS write to 9 only.
    rtl_wd_in[8] = 32'hBEEF; rtl_wd_in[9] = 32'hBEEF;
    rtl_wd_in[10] = 32'hBEEF; rtl_wd_in[11] = 32'hBEEF;
    rtl_write_reqs[11:8] = 4'hF;
    bus.waddr_data = 32'd36; bus.waddr_valid = 1;
    bus.wdata_data = 32'h1234_5678; bus.wdata_valid = 1;
    tick();
    bus.waddr_valid = 0; bus.wdata_valid = 0;
    check("blk_req_set", 32'(dut.ps_write_req), 32'd1);
    repeat (3) tick();
    check("blk_req_held", 32'(dut.ps_write_req), 32'd1);
    check("blk_no_wresp", 32'(bus.wresp_valid), 32'd0);
    rtl_read_reqs[9] = 1;
    tick();
    rtl_read_reqs[9] = 0;
    check("blk_rtl_rd", rtl_rd_out[9], 32'hBEEF);
    rtl_write_reqs = '0;
    #1;
    check("blk_wcomplete", 32'(dut.wcomplete), 32'd1);
    tick();
    check("blk_req_clr", 32'(dut.ps_write_req), 32'd0);
    check("blk_wc_pulse", 32'(dut.wcomplete), 32'd0);
    check("blk_wresp_v", 32'(bus.wresp_valid), 32'd1);
    check("blk_wresp_d", 32'(bus.wresp_data), 32'd0);
    repeat (2) tick();
    check("blk_wresp_hold", 32'(bus.wresp_valid), 32'd1);
    bus.wresp_ready = 1;
    tick();
    bus.wresp_ready = 0;
    check("blk_wresp_done", 32'(bus.wresp_valid), 32'd0);
    model[8] = 32'hBEEF; model[10] = 32'hBEEF; model[11] = 32'hBEEF;
    model[9] = 32'h1234_5678;
    do_psr("blk_ps_rd", 32'd36, model[9], 0);
    rtl_write_reqs[11:8] = 4'hF;
    do_psw("blk_neigh", 32'd48, 32'hCAFE, 0, 0, 0);
    rtl_write_reqs = '0;
    model[9] = 32'hBEEF;
    do_psr("blk_neigh_rd", 32'd48, 32'hCAFE, 1);

    // PS commit colliding with an RTL write to the same word.
    bus.waddr_data = 32'd0; bus.waddr_valid = 1;
    bus.wdata_data = 32'd250; bus.wdata_valid = 1;
    tick();
    bus.waddr_valid = 0; bus.wdata_valid = 0;
    rtl_write_reqs[0] = 1; rtl_wd_in[0] = W;
    #1;
    check("col_blocked", 32'(dut.wcomplete), 32'd0);
    tick();
    rtl_write_reqs[0] = 0;
    rtl_read_reqs[0] = 1;
    #1;
    check("col_deferred", 32'(dut.wcomplete), 32'd1);
    tick();
    rtl_read_reqs[0] = 0;
    check("col_rtl_first", rtl_rd_out[0], W);
    bus.wresp_ready = 1;
    tick();
    bus.wresp_ready = 0;
    do_psr("col_ps_final", 32'd0, 32'd250, 1);
    rtl_read(0, v);
    check("col_rtl_final", v, 32'd250);
    bus.waddr_valid = 1; bus.wdata_valid = 1;
    tick();
    bus.waddr_valid = 0; bus.wdata_valid = 0;
    #1;
    check("late_commit", 32'(dut.wcomplete), 32'd1);
    tick();
    rtl_write(0, W);
    bus.wresp_ready = 1;
    tick();
    bus.wresp_ready = 0;
    rtl_read(0, v);
    check("late_rtl_wins", v, W);
    model[0] = W;

    // Same-edge RTL write and read return the old word.
    rtl_write(2, W);
    rtl_write_reqs[2] = 1; rtl_wd_in[2] = 32'd10; rtl_read_reqs[2] = 1;
    tick();
    rtl_write_reqs[2] = 0; rtl_read_reqs[2] = 0;
    check("rw_same_old", rtl_rd_out[2], W);
    rtl_read(2, v);
    check("rw_next_new", v, 32'd10);
    model[2] = 32'd10;
    clr_rd_out = 1; rtl_read_reqs[2] = 1;
    tick();
    clr_rd_out = 0; rtl_read_reqs[2] = 0;
    check("clr_read_wins", rtl_rd_out[2], 32'd10);
    check("clr_other", rtl_rd_out[0], 32'd0);

    // Poll waits for rtl_rdy.
    rtl_rdy[3] = 0;
    do_psw("poll_wr", 32'd12, 32'd5, 0, 0, 0);
    check("poll_fresh_set", 32'(fresh_bits[3]), 32'd1);
    repeat (3) tick();
    check("poll_fresh_hold", 32'(fresh_bits[3]), 32'd1);
    rtl_rdy[3] = 1;
    repeat (2) tick();
    check("poll_fresh_clr", 32'(fresh_bits[3]), 32'd0);
    check("poll_rd_out", rtl_rd_out[3], 32'd5);

    // Randomized mix against the array model.
    for (int n = 0; n < 150; n++) begin
      int op, ix;
      logic [31:0] a, d;
      op = $urandom_range(0, 3);
      ix = $urandom_range(0, 70);
      a = (32'(ix) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      unique case (op)
        0: do_psw("rnd_w", a, d, $urandom_range(0, 4),
                  $urandom_range(0, 4), 1);
        1: do_psr("rnd_r", a, model[idx_of(a)], 1);
        2: begin
          if (ix > CEIL) ix = CEIL;
          rtl_write(ix, d);
          if (ix != CEIL) model[ix] = d;
        end
        default: begin
          if (ix > CEIL) ix = CEIL;
          rtl_read(ix, v);
          check("rnd_rtl_rd", v, model[ix]);
        end
      endcase
    end

    // Reset abandons a half-captured write.
    bus.waddr_data = 32'd16; bus.waddr_valid = 1;
    tick();
    bus.waddr_valid = 0;
    check("mid_aw_full", 32'(bus.waddr_ready), 32'd0);
    rst = 0;
    #2;
    check("mid_rst_ready", 32'(bus.waddr_ready), 32'd1);
    check("mid_rst_rd_out", rtl_rd_out[0], 32'd0);
    tick();
    rst = 1;
    model_reset();
    tick();
    do_psw("post_rst_w", 32'd16, 32'h0BAD_F00D, 2, 0, 0);
    do_psr("post_rst_r", 32'd16, 32'h0BAD_F00D, 0);
    do_psr("post_rst_mem", 32'd0, 32'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
